// File: rtl/pkt_frame_chk.sv
// pkt_frame_chk: sop/eop framing, length and payload-sequence checker for the packet FIFO output.
// Ports: clk, rst; din/din_vld/din_sop/din_eop in; dout*/pkt_done/pkt_ok/len_last/good_cnt/err_cnt out.
module pkt_frame_chk #(
  parameter int DATA_W    = 8,
  parameter int MIN_LEN   = 1,
  parameter int MAX_LEN   = 1024,
  parameter bit CHK_SEQ   = 1'b1,
  parameter int SEQ_START = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic              pkt_done,
  output logic              pkt_ok,
  output logic [15:0]       len_last,
  output logic [15:0]       good_cnt,
  output logic [15:0]       err_cnt
);

  localparam logic [16:0] MIN_L = 17'(MIN_LEN);
  localparam logic [16:0] MAX_L = 17'(MAX_LEN);
  localparam logic [DATA_W-1:0] SEQ_S = DATA_W'(SEQ_START);
  localparam logic [15:0] SAT = 16'hFFFF;

  typedef enum logic {
    IDLE,
    BODY
  } state_t;

  typedef struct packed {
    logic        v;
    logic        ok;
    logic [15:0] len;
  } cls_t;

  state_t state, state_nx;

  logic [15:0]       len, len_nx, len_inc;
  logic [DATA_W-1:0] seq_exp, seq_nx;
  logic              flag, flag_nx;
  logic              sop_bad, mid_bad;
  logic              body, stray, fwd;

  cls_t cls_a, cls_b, single;
  cls_t pend, pend_nx, emit;

  logic [1:0]  err_add;
  logic [16:0] err_sum;
  logic [15:0] err_nx, good_nx;

  function automatic logic len_bad(input logic [15:0] l);
    return ({1'b0, l} < MIN_L) || ({1'b0, l} > MAX_L);
  endfunction

  assign body    = (state == BODY);
  assign len_inc = (len == SAT) ? len : len + 16'd1;
  assign sop_bad = CHK_SEQ && (din != SEQ_S);
  assign mid_bad = CHK_SEQ && (din != seq_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // cls_a is the earlier close of this cycle;
  // cls_b only exists for abort-by-sop plus a
  // single-byte packet in the same beat.
  always_comb begin
    state_nx = state;
    len_nx   = len;
    seq_nx   = seq_exp;
    flag_nx  = flag;
    cls_a    = '0;
    cls_b    = '0;
    single   = '0;
    stray    = 1'b0;
    fwd      = din_vld && (din_sop || body);
    if (din_vld) begin
      unique case (1'b1)
        din_sop: begin
          if (body) cls_a = '{1'b1, 1'b0, len};
          if (din_eop) begin
            // a lone sop&eop byte is still
            // held to the sop value rule
            single = '{1'b1,
                       !sop_bad && !len_bad(16'd1),
                       16'd1};
            if (body) cls_b = single;
            else      cls_a = single;
            state_nx = IDLE;
            len_nx   = '0;
            flag_nx  = 1'b0;
          end else begin
            state_nx = BODY;
            len_nx   = 16'd1;
            seq_nx   = din + DATA_W'(1);
            flag_nx  = sop_bad;
          end
        end
        (body && !din_sop): begin
          if (din_eop) begin
            // eop byte is a trailer: no seq check
            cls_a = '{1'b1,
                      !(flag || len_bad(len_inc)),
                      len_inc};
            state_nx = IDLE;
            len_nx   = '0;
            flag_nx  = 1'b0;
          end else begin
            len_nx  = len_inc;
            seq_nx  = din + DATA_W'(1);
            flag_nx = flag || mid_bad;
          end
        end
        default: stray = 1'b1;
      endcase
    end
  end

  // A double close can only start from BODY
  // and lands in IDLE, and the next entry to
  // BODY has no close, so one pending slot
  // always drains before it is needed twice.
  always_comb begin
    emit    = '0;
    pend_nx = '0;
    if (pend.v) begin
      emit    = pend;
      pend_nx = cls_a;
    end else if (cls_a.v) begin
      emit    = cls_a;
      pend_nx = cls_b;
    end
  end

  // stray byte and a bad close may land on
  // the same edge, hence a 2-bit increment
  always_comb begin
    err_add = {1'b0, emit.v && !emit.ok}
            + {1'b0, stray};
    err_sum = {1'b0, err_cnt} + {15'd0, err_add};
    err_nx  = err_sum[16] ? SAT : err_sum[15:0];
    good_nx = good_cnt;
    if (emit.v && emit.ok && good_cnt != SAT)
      good_nx = good_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len      <= '0;
      seq_exp  <= '0;
      flag     <= 1'b0;
      pend     <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      pkt_done <= 1'b0;
      pkt_ok   <= 1'b0;
      len_last <= '0;
      good_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      len      <= len_nx;
      seq_exp  <= seq_nx;
      flag     <= flag_nx;
      pend     <= pend_nx;
      if (fwd) dout <= din;
      dout_vld <= fwd;
      dout_sop <= fwd && din_sop;
      dout_eop <= fwd && din_eop;
      pkt_done <= emit.v;
      pkt_ok   <= emit.v && emit.ok;
      if (emit.v) len_last <= emit.len;
      good_cnt <= good_nx;
      err_cnt  <= err_nx;
    end
  end

endmodule

// File: tb/tb_pkt_frame_chk.sv
// tb_pkt_frame_chk: directed and random stimulus for pkt_frame_chk.
// Ports: none; drives the DUT and compares against a packet-level model.
module tb_pkt_frame_chk;

  localparam int DW        = 8;
  localparam int MIN_LEN   = 1;
  localparam int MAX_LEN   = 1024;
  localparam bit CHK_SEQ   = 1'b1;
  localparam int SEQ_START = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_vld = 1'b0;
  logic          din_sop = 1'b0;
  logic          din_eop = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_vld, dout_sop, dout_eop;
  logic          pkt_done, pkt_ok;
  logic [15:0]   len_last, good_cnt, err_cnt;

  pkt_frame_chk #(
    .DATA_W(DW), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN),
    .CHK_SEQ(CHK_SEQ), .SEQ_START(SEQ_START)
  ) dut (
    .clk(clk), .rst(rst),
    .din(din), .din_vld(din_vld),
    .din_sop(din_sop), .din_eop(din_eop),
    .dout(dout), .dout_vld(dout_vld),
    .dout_sop(dout_sop), .dout_eop(dout_eop),
    .pkt_done(pkt_done), .pkt_ok(pkt_ok),
    .len_last(len_last), .good_cnt(good_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int vld_seen = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               tag, got, want, $time);
    end
  endtask

  typedef struct {
    bit ok;
    int len;
  } cl_t;

  logic [7:0] pkt[$];
  cl_t        closeq[$];
  bit         in_pkt;
  int         m_good, m_err;
  logic [7:0] e_dout;
  bit         e_dvld, e_dsop, e_deop;
  bit         e_done, e_ok;
  int         e_len;

  function automatic int sat(input int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  function automatic cl_t judge(input bit has_eop);
    cl_t c;
    int n, last;
    bit bad;
    logic [7:0] nxt;
    n = pkt.size();
    bad = (n < MIN_LEN) || (n > MAX_LEN);
    if (CHK_SEQ) begin
      if (pkt[0] != 8'(SEQ_START)) bad = 1;
      last = has_eop ? n - 2 : n - 1;
      for (int i = 1; i <= last; i++) begin
        nxt = pkt[i-1] + 8'd1;
        if (pkt[i] != nxt) bad = 1;
      end
    end
    c.ok = !bad;
    c.len = sat(n);
    return c;
  endfunction

  task automatic model_reset();
    pkt.delete();
    closeq.delete();
    in_pkt = 0;
    m_good = 0; m_err = 0;
    e_dout = '0; e_dvld = 0; e_dsop = 0; e_deop = 0;
    e_done = 0; e_ok = 0; e_len = 0;
  endtask

  task automatic model_step(input bit v, input bit s,
                            input bit e, input logic [7:0] d);
    cl_t c;
    bit str;
    str = 0;
    if (v && (s || in_pkt)) begin
      e_dvld = 1; e_dsop = s; e_deop = e; e_dout = d;
    end else begin
      e_dvld = 0; e_dsop = 0; e_deop = 0;
    end
    if (v) begin
      if (s) begin
        if (in_pkt) begin
          c = judge(0);
          c.ok = 0;
          closeq.push_back(c);
        end
        pkt.delete();
        pkt.push_back(d);
        in_pkt = 1;
        if (e) begin
          closeq.push_back(judge(1));
          pkt.delete();
          in_pkt = 0;
        end
      end else if (in_pkt) begin
        pkt.push_back(d);
        if (e) begin
          closeq.push_back(judge(1));
          pkt.delete();
          in_pkt = 0;
        end
      end else begin
        str = 1;
      end
    end
    e_done = 0; e_ok = 0;
    if (closeq.size() > 0) begin
      c = closeq.pop_front();
      e_done = 1; e_ok = c.ok; e_len = c.len;
      if (c.ok) m_good = sat(m_good + 1);
      else      m_err  = sat(m_err + 1);
    end
    if (str) m_err = sat(m_err + 1);
  endtask

  task automatic compare_all();
    chk("dout_vld", dout_vld, e_dvld);
    chk("dout_sop", dout_sop, e_dsop);
    chk("dout_eop", dout_eop, e_deop);
    chk("dout", dout, e_dout);
    chk("pkt_done", pkt_done, e_done);
    chk("pkt_ok", pkt_ok, e_ok);
    chk("len_last", len_last, e_len);
    chk("good_cnt", good_cnt, m_good);
    chk("err_cnt", err_cnt, m_err);
    if (dout_vld) vld_seen++;
  endtask

  task automatic drive(input bit v, input bit s,
                       input bit e, input logic [7:0] d);
    din_vld = v; din_sop = s; din_eop = e; din = d;
    model_step(v, s, e, d);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 1'($urandom), 1'($urandom), 8'($urandom));
  endtask

  // rst asserted between edges: outputs must clear at once
  task automatic do_reset();
    din_vld = 0; din_sop = 0; din_eop = 0;
    rst = 1;
    model_reset();
    #2;
    compare_all();
    @(posedge clk); #1;
    rst = 0;
    compare_all();
  endtask

  // sends indices first..stop-1 of an n-byte packet
  task automatic send_pkt(input int n, input int first,
                          input int stop, input int bad_idx,
                          input bit gaps);
    logic [7:0] b;
    for (int i = first; i < n && i < stop; i++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        idle(1 + $urandom_range(0, 2));
      b = 8'(SEQ_START + i);
      if (i == n - 1) b = gaps ? 8'($urandom) : 8'd1;
      if (i == bad_idx) b = 8'h00;
      drive(1, i == 0, i == n - 1, b);
    end
  endtask

  initial begin
    int k, n;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // T1: 999-byte good packet
    send_pkt(999, 0, 999, -1, 0);
    chk("t1_done", pkt_done, 1);
    chk("t1_ok", pkt_ok, 1);
    chk("t1_len", len_last, 999);
    idle(2);
    chk("t1_good", good_cnt, 1);

    // T2: 10 packets with 20-cycle gaps
    do_reset();
    vld_seen = 0;
    for (int p = 0; p < 10; p++) begin
      send_pkt(999, 0, 999, -1, 0);
      idle(20);
    end
    chk("t2_good", good_cnt, 10);
    chk("t2_err", err_cnt, 0);
    chk("t2_vld", vld_seen, 9990);

    // T3: sop at byte 500 aborts the first packet
    do_reset();
    send_pkt(999, 0, 499, -1, 0);
    send_pkt(999, 0, 1, -1, 0);
    chk("t3_done", pkt_done, 1);
    chk("t3_ok", pkt_ok, 0);
    chk("t3_len", len_last, 499);
    send_pkt(999, 1, 999, -1, 0);
    idle(2);
    chk("t3_err", err_cnt, 1);
    chk("t3_good", good_cnt, 1);

    // T4: stray byte in IDLE
    do_reset();
    drive(1, 0, 0, 8'h55);
    chk("t4_fwd", dout_vld, 0);
    chk("t4_done", pkt_done, 0);
    chk("t4_err", err_cnt, 1);

    // T5: corrupted byte, then oversize packet
    do_reset();
    send_pkt(999, 0, 999, 9, 0);
    chk("t5_ok", pkt_ok, 0);
    chk("t5_done", pkt_done, 1);
    idle(1);
    chk("t5_err", err_cnt, 1);
    send_pkt(MAX_LEN + 76, 0, MAX_LEN + 76, -1, 0);
    chk("t5_big_ok", pkt_ok, 0);
    chk("t5_big_len", len_last, MAX_LEN + 76);
    idle(1);
    chk("t5_big_err", err_cnt, 2);

    // T6: single byte, double close, reset mid-packet
    do_reset();
    drive(1, 1, 1, 8'h01);
    chk("t6_done", pkt_done, 1);
    chk("t6_ok", pkt_ok, 1);
    chk("t6_len", len_last, 1);
    send_pkt(10, 0, 5, -1, 0);
    drive(1, 1, 1, 8'h01);
    chk("t6_abort_ok", pkt_ok, 0);
    chk("t6_abort_len", len_last, 5);
    idle(1);
    chk("t6_second_done", pkt_done, 1);
    chk("t6_second_ok", pkt_ok, 1);
    chk("t6_second_len", len_last, 1);
    send_pkt(50, 0, 20, -1, 0);
    do_reset();
    chk("t6_rst_good", good_cnt, 0);
    chk("t6_rst_err", err_cnt, 0);
    chk("t6_rst_vld", dout_vld, 0);

    // random mix of good, corrupt, aborted, stray, single
    do_reset();
    for (int it = 0; it < 400; it++) begin
      k = $urandom_range(0, 9);
      n = $urandom_range(2, 30);
      case (k)
        0: drive(1, 0, 1'($urandom), 8'($urandom));
        1: drive(1, 1, 1,
                 $urandom_range(0, 1) ? 8'd1 : 8'($urandom));
        2: send_pkt(n, 0, $urandom_range(1, n - 1), -1, 1);
        3: send_pkt(n, 0, n, $urandom_range(0, n - 1), 1);
        default: send_pkt(n, 0, n, -1, 1);
      endcase
      idle($urandom_range(0, 3));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
